// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, funct codes, ALU controls, control-FSM states.
// Intended for reuse by the datapath and by assembler-level tests.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       ir_write;
        logic       pc_en;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alucontrol;
        logic [1:0] pc_src;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// R-type funct -> ALU control map; valid_o flags functs the datapath supports.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alucontrol_o,
    output logic       valid_o
);

    always_comb begin
        valid_o      = 1'b1;
        alucontrol_o = ALU_ADD;
        case (funct_i)
            FUNCT_ADD: alucontrol_o = ALU_ADD;
            FUNCT_SUB: alucontrol_o = ALU_SUB;
            FUNCT_AND: alucontrol_o = ALU_AND;
            FUNCT_OR:  alucontrol_o = ALU_OR;
            FUNCT_SLT: alucontrol_o = ALU_SLT;
            default:   valid_o      = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM. Outputs decode from the registered state; the
// handshake-qualified strobes (ir_write, pc_en) also look at same-cycle inputs.
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alucontrol,
    output logic [1:0] pc_src,
    output logic       mem_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state
);

    state_e     state_q;
    logic [2:0] funct_alu;
    logic       funct_ok;
    logic       decode_ok;
    ctrl_t      ctrl;

    alu_decoder u_alu_decoder (
        .funct_i      (funct),
        .alucontrol_o (funct_alu),
        .valid_o      (funct_ok)
    );

    assign decode_ok = op_supported(op) && ((op != OP_RTYPE) || funct_ok);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    if (!decode_ok) begin
                        state_q <= S_FETCH;
                    end else begin
                        case (op)
                            OP_LW, OP_SW: state_q <= S_MEMADR;
                            OP_RTYPE:     state_q <= S_EXEC;
                            OP_BEQ:       state_q <= S_BRANCH;
                            OP_ADDI:      state_q <= S_ADDIEX;
                            OP_J:         state_q <= S_JUMP;
                            default:      state_q <= S_FETCH;
                        endcase
                    end
                end
                S_MEMADR: state_q <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
                S_MEMWR:  if (mem_ready) state_q <= S_FETCH;
                S_EXEC:   state_q <= S_ALUWB;
                S_ADDIEX: state_q <= S_ADDIWB;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alucontrol = ALU_ADD;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_en      = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_IMMSH;
                ctrl.alucontrol = ALU_ADD;
                ctrl.illegal    = !decode_ok;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alucontrol = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req   = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_REG;
                ctrl.alucontrol = funct_alu;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_REG;
                ctrl.alucontrol = ALU_SUB;
                ctrl.pc_src     = PCSRC_ALUOUT;
                ctrl.pc_en      = zero;
            end
            S_JUMP: begin
                ctrl.pc_src = PCSRC_JUMP;
                ctrl.pc_en  = 1'b1;
            end
            default: ctrl = '0;
        endcase
        // Side-effecting strobes are held off for the whole reset cycle.
        if (!rst) begin
            ctrl.mem_req   = 1'b0;
            ctrl.ir_write  = 1'b0;
            ctrl.pc_en     = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.reg_write = 1'b0;
            ctrl.illegal   = 1'b0;
        end
    end

    assign mem_req    = ctrl.mem_req;
    assign iord       = ctrl.iord;
    assign ir_write   = ctrl.ir_write;
    assign pc_en      = ctrl.pc_en;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alucontrol = ctrl.alucontrol;
    assign pc_src     = ctrl.pc_src;
    assign mem_write  = ctrl.mem_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign illegal    = ctrl.illegal;
    assign state      = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete, same cycle
- mem_req  out  1  memory access request
- iord  out  1  address source: 0 = PC, 1 = ALU out
- ir_write  out  1  instruction register load
- pc_en  out  1  PC load
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = imm_ext, 11 = imm_ext<<2
- alucontrol  out  3  ALU function
- pc_src  out  2  00 = ALU result, 01 = ALU out reg, 10 = jump target
- mem_write  out  1  memory write
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = read data
- reg_write  out  1  register file write
- illegal  out  1  one-cycle unsupported-instruction pulse
- state  out  4  current state, debug

Function
REQ-002 SHALL be a Moore FSM with state codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-003 Any output not listed for a state SHALL be 0.
REQ-004 FETCH SHALL drive mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alucontrol=010.
REQ-005 In FETCH, ir_write and pc_en SHALL be 1 only when mem_ready=1; FETCH→DECODE on mem_ready=1, else hold.
REQ-006 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alucontrol=010.
REQ-007 DECODE SHALL branch on op: 100011/101011→MEMADR; 000000→EXEC; 000100→BRANCH; 001000→ADDIEX; 000010→JUMP.
REQ-008 Any other op in DECODE, or op=000000 with an unsupported funct, SHALL pulse illegal=1 and go to FETCH with no register or memory write.
REQ-009 MEMADR and ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alucontrol=010.
REQ-010 MEMADR SHALL go to MEMRD for op=100011, else to MEMWR.
REQ-011 MEMRD SHALL drive mem_req=1, iord=1; MEMRD→MEMWB on mem_ready=1, else hold.
REQ-012 MEMWB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-013 MEMWR SHALL drive mem_req=1, iord=1, mem_write=1; MEMWR→FETCH on mem_ready=1, else hold with signals stable.
REQ-014 EXEC SHALL drive alu_src_a=1, alu_src_b=00, alucontrol from funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
REQ-015 ALUWB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-016 ADDIWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-017 EXEC→ALUWB and ADDIEX→ADDIWB unconditionally; ALUWB and ADDIWB→FETCH.
REQ-018 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alucontrol=110, pc_src=01, pc_en=zero, then go to FETCH.
REQ-019 JUMP SHALL drive pc_src=10, pc_en=1, then go to FETCH.
REQ-020 With mem_ready tied 1, latency SHALL be: lw 5 cycles; sw, R-type and addi 4; beq and j 3.
REQ-021 state output SHALL equal the registered state code.

Reset
REQ-022 rst=0 at a clk edge SHALL load FETCH, in any state, including mid-wait in MEMRD or MEMWR.
REQ-023 While rst=0, mem_req, ir_write, pc_en, mem_write, reg_write and illegal SHALL be forced 0.
REQ-024 After rst returns to 1, the first cycle SHALL be FETCH with the REQ-004 outputs.

Structure
REQ-025 Opcode, funct and alucontrol codes, and state codes SHALL live in shared package mips_pkg, reusable by datapath and assembler tests.
REQ-026 The funct→alucontrol map SHALL be a sub-module alu_decoder (combinational, 6→3 bits, valid flag), instantiated once.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset, then op=100011 with mem_ready=1 → state sequence 0,1,2,3,4,0; reg_write=1 only in state 4, with mem_to_reg=1.
- op=101011, mem_ready low 3 cycles in MEMWR → mem_write=1 for 4 cycles, then state 0; no reg_write.
- op=000000, funct=101010 → EXEC alucontrol=111, ALUWB reg_write=1, reg_dst=1; 4 cycles total.
- op=000100 with zero=1, then with zero=0 → pc_en=1, then 0, in BRANCH; pc_src=01 both times.
- op=111111 → illegal=1 for exactly one cycle in DECODE, next state 0, no writes.
- rst=0 asserted while in MEMRD → all enables 0 that cycle, state 0 next cycle.
